// File: rtl/area_scan_gen.sv
// Row-major coordinate scanner feeding external area decoders; registers one
// pixel record per coordinate behind a valid/ready handshake and counts hits per frame.
module area_scan_gen #(
   parameter logic [6:0] ROWS = 7'd32,
   parameter logic [6:0] COLS = 7'd3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        loop_en,
   output logic [6:0]  row_now,
   output logic [6:0]  col_now,
   input  logic        judge1,
   input  logic        judge2,
   input  logic        judge3,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [6:0]  pix_row,
   output logic [6:0]  pix_col,
   output logic [1:0]  pix_level,
   output logic        busy,
   output logic        frame_done,
   output logic [13:0] hit_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [13:0] ACC_MAX = 14'h3FFF;

   state_t      state_q, state_d;
   logic [6:0]  row_q, row_d;
   logic [6:0]  col_q, col_d;
   logic        valid_q, valid_d;
   logic [6:0]  prow_q, prow_d;
   logic [6:0]  pcol_q, pcol_d;
   logic [1:0]  plev_q, plev_d;
   logic        done_q, done_d;
   logic [13:0] hit_q, hit_d;
   logic [13:0] acc_q, acc_d;

   logic        adv;
   logic        xfer;
   logic        last_pos;
   logic [1:0]  level_w;

   assign adv      = !valid_q || pix_ready;
   assign xfer     = valid_q && pix_ready;
   assign last_pos = (row_q == ROWS) && (col_q == COLS);

   always_comb begin
      level_w = 2'd0;
      if (judge1) begin
         level_w = 2'd1;
      end else if (judge2) begin
         level_w = 2'd2;
      end else if (judge3) begin
         level_w = 2'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= 7'd1;
         col_q   <= 7'd1;
         valid_q <= 1'b0;
         prow_q  <= 7'd0;
         pcol_q  <= 7'd0;
         plev_q  <= 2'd0;
         done_q  <= 1'b0;
         hit_q   <= 14'd0;
         acc_q   <= 14'd0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         valid_q <= valid_d;
         prow_q  <= prow_d;
         pcol_q  <= pcol_d;
         plev_q  <= plev_d;
         done_q  <= done_d;
         hit_q   <= hit_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      valid_d = valid_q;
      prow_d  = prow_q;
      pcol_d  = pcol_q;
      plev_d  = plev_q;
      done_d  = 1'b0;
      hit_d   = hit_q;
      acc_d   = acc_q;

      case (state_q)
         IDLE: begin
            if (xfer) begin
               valid_d = 1'b0;
            end
            if (start) begin
               row_d   = 7'd1;
               col_d   = 7'd1;
               acc_d   = 14'd0;
               state_d = SCAN;
            end
         end

         SCAN: begin
            // A stalled record freezes both the record and the counters, so
            // the decoders keep seeing the coordinate that is still owed.
            if (adv) begin
               valid_d = 1'b1;
               prow_d  = row_q;
               pcol_d  = col_q;
               plev_d  = level_w;
               if ((level_w != 2'd0) && (acc_q != ACC_MAX)) begin
                  acc_d = acc_q + 14'd1;
               end
               if (last_pos) begin
                  state_d = DRAIN;
               end else if (col_q == COLS) begin
                  col_d = 7'd1;
                  row_d = row_q + 7'd1;
               end else begin
                  col_d = col_q + 7'd1;
               end
            end
         end

         DRAIN: begin
            if (xfer) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               hit_d   = acc_q;
               if (loop_en) begin
                  row_d   = 7'd1;
                  col_d   = 7'd1;
                  acc_d   = 14'd0;
                  state_d = SCAN;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign row_now    = row_q;
   assign col_now    = col_q;
   assign pix_valid  = valid_q;
   assign pix_row    = prow_q;
   assign pix_col    = pcol_q;
   assign pix_level  = plev_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign hit_cnt    = hit_q;

endmodule

// File: tb/tb_area_scan_gen.sv
// Directed bench for area_scan_gen: 2x3 main instance, 1x2 looping instance
// and a 1x1 instance, each driven by scenario tasks with hand-computed results.
module tb_area_scan_gen;

   logic clk;
   logic rst;

   int checks;
   int failures;

   // 2x3 instance
   logic        start, loop_en, pix_ready;
   logic        judge1, judge2, judge3, jen;
   logic [6:0]  row_now, col_now, pix_row, pix_col;
   logic [1:0]  pix_level;
   logic        pix_valid, busy, frame_done;
   logic [13:0] hit_cnt;

   // 1x2 instance
   logic        l_start, l_loop_en, l_pix_ready;
   logic [6:0]  l_row_now, l_col_now, l_pix_row, l_pix_col;
   logic [1:0]  l_pix_level;
   logic        l_pix_valid, l_busy, l_frame_done;
   logic [13:0] l_hit_cnt;

   // 1x1 instance
   logic        o_start, o_loop_en, o_pix_ready;
   logic [6:0]  o_row_now, o_col_now, o_pix_row, o_pix_col;
   logic [1:0]  o_pix_level;
   logic        o_pix_valid, o_busy, o_frame_done;
   logic [13:0] o_hit_cnt;

   logic zero_j;
   assign zero_j = 1'b0;

   area_scan_gen #(.ROWS(7'd2), .COLS(7'd3)) u_dut (
      .clk(clk), .rst(rst), .start(start), .loop_en(loop_en),
      .row_now(row_now), .col_now(col_now),
      .judge1(judge1), .judge2(judge2), .judge3(judge3),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_row(pix_row), .pix_col(pix_col), .pix_level(pix_level),
      .busy(busy), .frame_done(frame_done), .hit_cnt(hit_cnt)
   );

   area_scan_gen #(.ROWS(7'd1), .COLS(7'd2)) u_loop (
      .clk(clk), .rst(rst), .start(l_start), .loop_en(l_loop_en),
      .row_now(l_row_now), .col_now(l_col_now),
      .judge1(zero_j), .judge2(zero_j), .judge3(zero_j),
      .pix_valid(l_pix_valid), .pix_ready(l_pix_ready),
      .pix_row(l_pix_row), .pix_col(l_pix_col), .pix_level(l_pix_level),
      .busy(l_busy), .frame_done(l_frame_done), .hit_cnt(l_hit_cnt)
   );

   area_scan_gen #(.ROWS(7'd1), .COLS(7'd1)) u_one (
      .clk(clk), .rst(rst), .start(o_start), .loop_en(o_loop_en),
      .row_now(o_row_now), .col_now(o_col_now),
      .judge1(zero_j), .judge2(zero_j), .judge3(zero_j),
      .pix_valid(o_pix_valid), .pix_ready(o_pix_ready),
      .pix_row(o_pix_row), .pix_col(o_pix_col), .pix_level(o_pix_level),
      .busy(o_busy), .frame_done(o_frame_done), .hit_cnt(o_hit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Area decoder model: judge2 at (1,2), judge1 and judge3 at (2,1).
   always_comb begin
      judge1 = 1'b0;
      judge2 = 1'b0;
      judge3 = 1'b0;
      if (jen) begin
         if (row_now == 7'd1 && col_now == 7'd2) judge2 = 1'b1;
         if (row_now == 7'd2 && col_now == 7'd1) begin
            judge1 = 1'b1;
            judge3 = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (row_now !== 7'd1 || col_now !== 7'd1 || pix_valid !== 1'b0 || pix_row !== 7'd0 ||
          pix_col !== 7'd0 || pix_level !== 2'd0 || busy !== 1'b0 || frame_done !== 1'b0 ||
          hit_cnt !== 14'd0)
         begin
         failures++;
         $display("FAIL reset_2x3 got row=%0d col=%0d v=%0b pr=%0d pc=%0d pl=%0d busy=%0b fd=%0b hit=%0d exp row=1 col=1 rest 0",
                  row_now, col_now, pix_valid, pix_row, pix_col, pix_level, busy, frame_done, hit_cnt);
      end
      checks++;
      if (l_busy !== 1'b0 || l_pix_valid !== 1'b0 || o_busy !== 1'b0 || o_pix_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_small got lb=%0b lv=%0b ob=%0b ov=%0b exp all 0",
                  l_busy, l_pix_valid, o_busy, o_pix_valid);
      end
      rst = 1'b0;
   endtask

   // One 2x3 frame with pix_ready held high; lev_* give the expected levels.
   task automatic run_frame(input string name, input logic [1:0] lev [6], input logic [13:0] exp_hit);
      pix_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || row_now !== 7'd1 || col_now !== 7'd1 || pix_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_start got busy=%0b row=%0d col=%0d v=%0b exp busy=1 row=1 col=1 v=0",
                  name, busy, row_now, col_now, pix_valid);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (pix_valid !== 1'b1 || pix_row !== 7'(k / 3 + 1) || pix_col !== 7'(k % 3 + 1) ||
             pix_level !== lev[k] || frame_done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_pix%0d got v=%0b (%0d,%0d) lvl=%0d fd=%0b busy=%0b exp v=1 (%0d,%0d) lvl=%0d fd=0 busy=1",
                     name, k, pix_valid, pix_row, pix_col, pix_level, frame_done, busy,
                     k / 3 + 1, k % 3 + 1, lev[k]);
         end
      end
      tick();
      checks++;
      if (frame_done !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0 || hit_cnt !== exp_hit) begin
         failures++;
         $display("FAIL %s_end got fd=%0b v=%0b busy=%0b hit=%0d exp fd=1 v=0 busy=0 hit=%0d",
                  name, frame_done, pix_valid, busy, hit_cnt, exp_hit);
      end
      tick();
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || hit_cnt !== exp_hit) begin
         failures++;
         $display("FAIL %s_after got fd=%0b busy=%0b hit=%0d exp fd=0 busy=0 hit=%0d",
                  name, frame_done, busy, hit_cnt, exp_hit);
      end
   endtask

   task automatic test_basic();
      logic [1:0] lev [6];
      lev = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      jen = 1'b0;
      run_frame("basic", lev, 14'd0);
   endtask

   task automatic test_levels();
      logic [1:0] lev [6];
      lev = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
      jen = 1'b1;
      run_frame("levels", lev, 14'd2);
      jen = 1'b0;
   endtask

   task automatic test_backpressure();
      int          got;
      logic        stall;
      logic        r;
      logic        done_seen;
      logic [6:0]  sr, sc;
      logic [1:0]  sl;
      logic        pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      jen = 1'b1;
      pix_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      got = 0;
      stall = 1'b0;
      done_seen = 1'b0;
      sr = 7'd0;
      sc = 7'd0;
      sl = 2'd0;
      for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
         if (stall) begin
            checks++;
            if (pix_valid !== 1'b1 || pix_row !== sr || pix_col !== sc || pix_level !== sl) begin
               failures++;
               $display("FAIL bp_hold cyc=%0d got v=%0b (%0d,%0d) lvl=%0d exp v=1 (%0d,%0d) lvl=%0d",
                        cyc, pix_valid, pix_row, pix_col, pix_level, sr, sc, sl);
            end
         end
         if (frame_done === 1'b1) done_seen = 1'b1;
         r = (cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1));
         pix_ready = r;
         if (pix_valid === 1'b1 && r) begin
            checks++;
            if (got >= 6 || pix_row !== 7'(got / 3 + 1) || pix_col !== 7'(got % 3 + 1)) begin
               failures++;
               $display("FAIL bp_seq idx=%0d got (%0d,%0d) exp (%0d,%0d)",
                        got, pix_row, pix_col, got / 3 + 1, got % 3 + 1);
            end
            got++;
         end
         stall = (pix_valid === 1'b1) && !r;
         sr = pix_row;
         sc = pix_col;
         sl = pix_level;
         tick();
      end
      checks++;
      if (!done_seen || got != 6 || hit_cnt !== 14'd2) begin
         failures++;
         $display("FAIL bp_frame got done=%0b count=%0d hit=%0d exp done=1 count=6 hit=2",
                  done_seen, got, hit_cnt);
      end
      pix_ready = 1'b1;
      jen = 1'b0;
      tick();
   endtask

   task automatic test_midreset();
      logic seen_done;
      pix_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (pix_valid !== 1'b1 || pix_row !== 7'd1 || pix_col !== 7'd3) begin
         failures++;
         $display("FAIL mr_third got v=%0b (%0d,%0d) exp v=1 (1,3)", pix_valid, pix_row, pix_col);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (row_now !== 7'd1 || col_now !== 7'd1 || pix_valid !== 1'b0 || pix_row !== 7'd0 ||
          pix_col !== 7'd0 || pix_level !== 2'd0 || busy !== 1'b0 || frame_done !== 1'b0 ||
          hit_cnt !== 14'd0) begin
         failures++;
         $display("FAIL mr_reset got row=%0d col=%0d v=%0b pr=%0d pc=%0d busy=%0b fd=%0b hit=%0d exp row=1 col=1 rest 0",
                  row_now, col_now, pix_valid, pix_row, pix_col, busy, frame_done, hit_cnt);
      end
      seen_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (frame_done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin
         failures++;
         $display("FAIL mr_quiet got stray frame_done or busy after reset exp none");
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if (pix_valid !== 1'b1 || pix_row !== 7'd1 || pix_col !== 7'd1) begin
         failures++;
         $display("FAIL mr_restart got v=%0b (%0d,%0d) exp v=1 (1,1)", pix_valid, pix_row, pix_col);
      end
      seen_done = 1'b0;
      for (int k = 0; k < 10 && !seen_done; k++) begin
         tick();
         if (frame_done === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (!seen_done || busy !== 1'b0) begin
         failures++;
         $display("FAIL mr_finish got done=%0b busy=%0b exp done=1 busy=0", seen_done, busy);
      end
      tick();
   endtask

   task automatic test_loop();
      logic       ev [6];
      logic       ed [6];
      logic [6:0] ec [6];
      ev = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      ec = '{7'd1, 7'd2, 7'd0, 7'd1, 7'd2, 7'd0};
      l_pix_ready = 1'b1;
      l_loop_en = 1'b1;
      l_start = 1'b1;
      tick();
      l_start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         // stray start requests while the frame is running
         l_start = (k == 0 || k == 3) ? 1'b1 : 1'b0;
         tick();
         checks++;
         if (l_pix_valid !== ev[k] || l_frame_done !== ed[k] || l_busy !== 1'b1 ||
             (ev[k] && (l_pix_row !== 7'd1 || l_pix_col !== ec[k]))) begin
            failures++;
            $display("FAIL loop_step%0d got v=%0b fd=%0b busy=%0b (%0d,%0d) exp v=%0b fd=%0b busy=1 col=%0d",
                     k, l_pix_valid, l_frame_done, l_busy, l_pix_row, l_pix_col, ev[k], ed[k], ec[k]);
         end
      end
      l_start = 1'b0;
      l_loop_en = 1'b0;
      tick();
      tick();
      l_start = 1'b1;
      tick();
      l_start = 1'b0;
      checks++;
      if (l_frame_done !== 1'b1 || l_busy !== 1'b0 || l_hit_cnt !== 14'd0) begin
         failures++;
         $display("FAIL loop_stop got fd=%0b busy=%0b hit=%0d exp fd=1 busy=0 hit=0",
                  l_frame_done, l_busy, l_hit_cnt);
      end
      tick();
      checks++;
      if (l_busy !== 1'b0 || l_pix_valid !== 1'b0 || l_row_now !== 7'd1 || l_col_now !== 7'd2) begin
         failures++;
         $display("FAIL loop_idle got busy=%0b v=%0b row=%0d col=%0d exp busy=0 v=0 row=1 col=2",
                  l_busy, l_pix_valid, l_row_now, l_col_now);
      end
   endtask

   task automatic test_single();
      o_pix_ready = 1'b1;
      o_start = 1'b1;
      tick();
      o_start = 1'b0;
      checks++;
      if (o_busy !== 1'b1 || o_pix_valid !== 1'b0 || o_row_now !== 7'd1 || o_col_now !== 7'd1) begin
         failures++;
         $display("FAIL one_scan got busy=%0b v=%0b row=%0d col=%0d exp busy=1 v=0 row=1 col=1",
                  o_busy, o_pix_valid, o_row_now, o_col_now);
      end
      tick();
      checks++;
      if (o_busy !== 1'b1 || o_pix_valid !== 1'b1 || o_pix_row !== 7'd1 || o_pix_col !== 7'd1 ||
          o_pix_level !== 2'd0) begin
         failures++;
         $display("FAIL one_pix got busy=%0b v=%0b (%0d,%0d) lvl=%0d exp busy=1 v=1 (1,1) lvl=0",
                  o_busy, o_pix_valid, o_pix_row, o_pix_col, o_pix_level);
      end
      tick();
      checks++;
      if (o_frame_done !== 1'b1 || o_busy !== 1'b0 || o_pix_valid !== 1'b0 || o_hit_cnt !== 14'd0) begin
         failures++;
         $display("FAIL one_done got fd=%0b busy=%0b v=%0b hit=%0d exp fd=1 busy=0 v=0 hit=0",
                  o_frame_done, o_busy, o_pix_valid, o_hit_cnt);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      start = 1'b0;
      loop_en = 1'b0;
      pix_ready = 1'b1;
      jen = 1'b0;
      l_start = 1'b0;
      l_loop_en = 1'b0;
      l_pix_ready = 1'b1;
      o_start = 1'b0;
      o_loop_en = 1'b0;
      o_pix_ready = 1'b1;
      test_reset();
      test_basic();
      test_levels();
      test_backpressure();
      test_midreset();
      test_loop();
      test_single();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
